// File: rtl/monster_ctrl.sv
// Per-page monster lifecycle: ALIVE -> SQUASH (timed) -> DEAD -> respawn on the next new page.
// Every output is a registered image of the post-edge state, so decisions show one edge later.
module monster_ctrl #(
  parameter int DEATH_FRAMES = 16,
  parameter int NUM_MAX      = 99,
  parameter int PW           = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_tick,
  input  logic [PW-1:0] page_index,
  input  logic          touch_v,
  input  logic          touch_h,
  output logic          monster_active,
  output logic          monster_squash,
  output logic          stomp_pulse,
  output logic          hurt_pulse,
  output logic [7:0]    monster_num,
  output logic [1:0]    state_o
);

  localparam int              TW         = $clog2(DEATH_FRAMES + 1);
  localparam logic [TW-1:0]   TIMER_INIT = TW'(DEATH_FRAMES);
  localparam logic [TW-1:0]   TIMER_ONE  = TW'(1);
  localparam logic [7:0]      NUM_SAT    = 8'(NUM_MAX);

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'b00,
    ST_SQUASH = 2'b01,
    ST_DEAD   = 2'b10
  } state_t;

  state_t        r_state;
  logic [PW-1:0] r_max_page;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_num;
  logic          r_prev_v;
  logic          r_prev_h;
  logic          r_stomp;
  logic          r_hurt;
  logic          r_active;
  logic          r_squash;

  state_t        w_nxt_state;
  logic [PW-1:0] w_nxt_max;
  logic [TW-1:0] w_nxt_timer;
  logic [7:0]    w_nxt_num;
  logic          w_stomp;
  logic          w_hurt;
  logic          w_on_page;
  logic          w_new_page;
  logic          w_rise_v;
  logic          w_rise_h;
  logic          w_nxt_on_page;

  function automatic logic [7:0] sat_inc(input logic [7:0] n);
    return (n >= NUM_SAT) ? n : n + 8'd1;
  endfunction

  assign w_on_page     = (page_index == r_max_page);
  assign w_new_page    = (page_index > r_max_page);
  assign w_rise_v      = touch_v & ~r_prev_v;
  assign w_rise_h      = touch_h & ~r_prev_h;
  assign w_nxt_max     = w_new_page ? page_index : r_max_page;
  // Visibility is judged against the max page as it stands after this edge.
  assign w_nxt_on_page = (page_index == w_nxt_max);

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    w_nxt_num   = r_num;
    w_stomp     = 1'b0;
    w_hurt      = 1'b0;
    case (r_state)
      ST_ALIVE: begin
        if (w_on_page && !w_new_page) begin
          if (w_rise_v) begin
            w_nxt_state = ST_SQUASH;
            w_nxt_timer = TIMER_INIT;
            w_nxt_num   = sat_inc(r_num);
            w_stomp     = 1'b1;
          end else if (w_rise_h) begin
            w_hurt = 1'b1;
          end
        end
      end
      ST_SQUASH: begin
        if (w_new_page) begin
          w_nxt_state = ST_ALIVE;
          w_nxt_timer = '0;
        end else if (frame_tick) begin
          if (r_timer <= TIMER_ONE) begin
            w_nxt_state = ST_DEAD;
            w_nxt_timer = '0;
          end else begin
            w_nxt_timer = r_timer - TIMER_ONE;
          end
        end
      end
      ST_DEAD: begin
        if (w_new_page) begin
          w_nxt_state = ST_ALIVE;
        end
      end
      default: begin
        w_nxt_state = ST_ALIVE;
        w_nxt_timer = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_ALIVE;
      r_max_page <= '0;
      r_timer    <= '0;
      r_num      <= '0;
      r_prev_v   <= 1'b0;
      r_prev_h   <= 1'b0;
      r_stomp    <= 1'b0;
      r_hurt     <= 1'b0;
      r_active   <= (page_index == '0);
      r_squash   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_max_page <= w_nxt_max;
      r_timer    <= w_nxt_timer;
      r_num      <= w_nxt_num;
      r_prev_v   <= touch_v;
      r_prev_h   <= touch_h;
      r_stomp    <= w_stomp;
      r_hurt     <= w_hurt;
      r_active   <= (w_nxt_state == ST_ALIVE) && w_nxt_on_page;
      r_squash   <= (w_nxt_state == ST_SQUASH) && w_nxt_on_page;
    end
  end

  assign monster_active = r_active;
  assign monster_squash = r_squash;
  assign stomp_pulse    = r_stomp;
  assign hurt_pulse     = r_hurt;
  assign monster_num    = r_num;
  assign state_o        = r_state;

endmodule
